pattern_checker: RTL and testbench
==================================

# pattern_checker

Receive-side companion to the on-chip 5-state pattern generator: samples a serial bit stream, acquires alignment to the repeating 0,0,1,0,1 sequence, and then checks every subsequent bit against it. It reports lock status, per-period and per-error pulses, and a saturating error count. It sits at the far end of the single-bit test link and serves as the self-check target for the generator.

## Interface
- PAT_LEN, 5: pattern period in bits.
- PATTERN, 5'b00101: pattern bits. MSB is transmitted first, so the sequence is 0,0,1,0,1.
- LOSS_THRESH, 3: number of consecutive mismatches while locked that drops lock.
- ERR_W, 16: width of the error counter.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies `in`. Only cycles where this is high are "valid bits".
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- period_pulse  out  1  one-cycle pulse for each completed period while LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatching bit while LOCKED.
- err_count  out  ERR_W  saturating count of mismatches seen in LOCKED.

## Operation
- **States:** HUNT, CONFIRM, LOCKED.
- **Internal registers:**
  - hist[PAT_LEN-1:0]: history shift register.
  - fill: 0..PAT_LEN.
  - phase: 0..PAT_LEN-1.
  - miss_run: 0..LOSS_THRESH.
  - The expected bit is PATTERN[PAT_LEN-1-phase].
- **Cycles with in_valid=0:** no register changes, and both pulses are 0.
- **HUNT:**
  - Each valid bit shifts into hist, and fill increments, saturating at PAT_LEN.
  - The window is {hist[PAT_LEN-2:0], in}. When the current bit brings fill to PAT_LEN and the window equals PATTERN, go to CONFIRM with phase=0.
- **CONFIRM:**
  - Each valid bit is compared with the expected bit.
  - On a mismatch, go to HUNT and clear fill to 0, so re-acquisition needs PAT_LEN fresh bits.
  - On a match, phase advances. A match at phase PAT_LEN-1 moves to LOCKED with phase=0 and miss_run=0.
  - CONFIRM does not touch err_count.
- **LOCKED:**
  - phase advances on every valid bit and wraps from PAT_LEN-1 to 0.
  - On a match, miss_run is set to 0.
  - On a mismatch: err_pulse=1, err_count increments (saturating at all ones), and miss_run increments.
  - If a mismatch makes miss_run equal LOSS_THRESH, go to HUNT, clear fill and miss_run, and keep err_count.
  - period_pulse=1 for each valid bit at phase PAT_LEN-1, whether that bit matched or not. It is also 0 on the bit that drops lock.
- **clr_err:**
  - Sets err_count to 0 and takes priority over a simultaneous increment.
  - Has no effect on state, phase, or miss_run.
- **rst:** overrides every other input.

## Timing
- All outputs are registered. Each reflects the valid bit sampled at the previous rising edge.
- **Reset values:**
  - State: HUNT.
  - Outputs: locked=0, period_pulse=0, err_pulse=0, err_count=0.
  - Internal: hist=0, fill=0, phase=0, miss_run=0.
- **Acquisition latency on a clean, aligned stream:** locked rises one cycle after the edge that samples the 2*PAT_LEN-th valid bit (the 10th by default).
- **Lock loss:** locked falls one cycle after the edge that samples the LOSS_THRESH-th consecutive mismatch. err_pulse is asserted in that same cycle.
- A valid bit sampled in the cycle rst is high is discarded.
- Reset in mid-acquisition or while locked returns every output to its reset value on the next cycle.

## Structure
- **Shared package (rx test-link):**
  - The state typedef (HUNT/CONFIRM/LOCKED).
  - PAT_LEN and PATTERN constants, shared with the generator so both ends cannot diverge.
- **Sub-module:** `sat_counter` (parameter W, inputs clr/inc, clr dominant) implements err_count. Everything else stays in pattern_checker.

## Test plan
- Reset, then 0,0,1,0,1 twice with in_valid held high → locked=1 after the 10th bit and err_count=0. Continuing the stream → period_pulse every 5th valid bit.
- Prefix 1,0,1, then the clean pattern → HUNT matches on the 8th bit and locked=1 after the 13th bit.
- While locked, flip one bit → err_pulse for one cycle, err_count=1, locked stays 1, and the next period_pulse arrives on schedule.
- While locked, flip 3 consecutive bits → err_count=3 and locked=0 after the 3rd. Then 10 clean aligned bits → locked=1 again with err_count still 3.
- in_valid toggling 1,0,1,0 over a clean stream → same lock point counted in valid bits, and no pulses in invalid cycles.
- ERR_W=2 with 5 isolated errors → err_count saturates at 3. clr_err coincident with a mismatch → err_count=0 while err_pulse=1.

Source files
------------

// File: rtl/pattern_checker_pkg.sv
// Shared definitions for the single-bit test link (generator and checker).
package pattern_checker_pkg;

    // Pattern period and content; MSB goes on the wire first.
    localparam int                PAT_LEN = 5;
    localparam logic [PAT_LEN-1:0] PATTERN = 5'b00101;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_checker_sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; the count sticks at all ones.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pattern_checker.sv
// Receive-side checker: acquires alignment to the repeating pattern,
// then flags every mismatching bit and drops lock after a run of misses.
module pattern_checker
    import pattern_checker_pkg::*;
#(
    parameter int                PAT_LEN     = pattern_checker_pkg::PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN    = pattern_checker_pkg::PATTERN,
    parameter int                LOSS_THRESH = 3,
    parameter int                ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             period_pulse,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam int PH_W   = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    state_t              state;
    logic [PAT_LEN-1:0]  hist;
    logic [FILL_W-1:0]   fill;
    logic [PH_W-1:0]     phase;
    logic [MISS_W-1:0]   miss_run;

    logic [PAT_LEN-1:0]  window;
    logic [FILL_W-1:0]   fill_nxt;
    logic                exp_bit;
    logic                mism;
    logic                phase_last;
    logic [PH_W-1:0]     phase_nxt;
    logic                err_inc;

    // Candidate window, saturating fill, expected bit and phase bookkeeping.
    always_comb begin
        window     = {hist[PAT_LEN-2:0], in};
        fill_nxt   = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
        exp_bit    = PATTERN[PH_W'(PAT_LEN - 1) - phase];
        mism       = in ^ exp_bit;
        phase_last = (phase == PH_W'(PAT_LEN - 1));
        phase_nxt  = phase_last ? '0 : phase + PH_W'(1);
        err_inc    = in_valid && (state == LOCKED) && mism;
    end

    // Acquisition / tracking FSM with registered status and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            hist         <= '0;
            fill         <= '0;
            phase        <= '0;
            miss_run     <= '0;
            locked       <= 1'b0;
            period_pulse <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            period_pulse <= 1'b0;
            err_pulse    <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        hist <= window;
                        fill <= fill_nxt;
                        if ((fill_nxt == FILL_W'(PAT_LEN)) && (window == PATTERN)) begin
                            state <= CONFIRM;
                            phase <= '0;
                        end
                    end
                    CONFIRM: begin
                        if (mism) begin
                            // A single slip restarts acquisition from scratch.
                            state <= HUNT;
                            fill  <= '0;
                            phase <= '0;
                        end else if (phase_last) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            phase    <= '0;
                            miss_run <= '0;
                        end else begin
                            phase <= phase_nxt;
                        end
                    end
                    LOCKED: begin
                        if (mism && (miss_run == MISS_W'(LOSS_THRESH - 1))) begin
                            // Loss of lock: no period pulse on this bit.
                            state     <= HUNT;
                            locked    <= 1'b0;
                            fill      <= '0;
                            miss_run  <= '0;
                            phase     <= '0;
                            err_pulse <= 1'b1;
                        end else begin
                            err_pulse    <= mism;
                            period_pulse <= phase_last;
                            phase        <= phase_nxt;
                            miss_run     <= mism ? miss_run + MISS_W'(1) : '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_err),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_pattern_checker.sv
// Directed bench with a reference scoreboard for pattern_checker.
module tb_pattern_checker;

    localparam logic [4:0] PAT = 5'b00101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in = 1'b0;
    logic        in_valid = 1'b0;
    logic        clr_err = 1'b0;
    logic        locked, period_pulse, err_pulse;
    logic [15:0] err_count;
    logic        locked2, period_pulse2, err_pulse2;
    logic [1:0]  err_count2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit lk;
        bit pp;
        bit ep;
        int cnt;
        int cnt2;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int       m_state = 0;   // 0 hunt, 1 confirm, 2 locked
    bit [4:0] m_hist = '0;
    int       m_fill = 0, m_phase = 0, m_miss = 0, m_cnt = 0, m_cnt2 = 0;
    bit       m_lk = 0;

    always #5 clk = ~clk;

    pattern_checker dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr_err(clr_err),
        .locked(locked), .period_pulse(period_pulse), .err_pulse(err_pulse),
        .err_count(err_count)
    );

    pattern_checker #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .clr_err(clr_err),
        .locked(locked2), .period_pulse(period_pulse2), .err_pulse(err_pulse2),
        .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic step(input bit b, input bit v = 1, input bit c = 0, input bit r = 0);
        exp_t e, g;
        bit   mis;
        in = b; in_valid = v; clr_err = c; rst = r;
        e.pp = 0; e.ep = 0;
        if (r) begin
            m_state = 0; m_hist = '0; m_fill = 0; m_phase = 0; m_miss = 0;
            m_cnt = 0; m_cnt2 = 0; m_lk = 0;
        end else begin
            if (v) begin
                mis = (b != PAT[4 - m_phase]);
                if (m_state == 0) begin
                    m_hist = {m_hist[3:0], b};
                    if (m_fill < 5) m_fill++;
                    if (m_fill == 5 && m_hist == PAT) begin m_state = 1; m_phase = 0; end
                end else if (m_state == 1) begin
                    if (mis) begin m_state = 0; m_fill = 0; m_phase = 0; end
                    else if (m_phase == 4) begin m_state = 2; m_lk = 1; m_phase = 0; m_miss = 0; end
                    else m_phase++;
                end else begin
                    if (mis) begin
                        e.ep = 1; m_miss++;
                        if (m_cnt < 65535) m_cnt++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end else m_miss = 0;
                    if (m_miss == 3) begin
                        m_state = 0; m_lk = 0; m_fill = 0; m_miss = 0; m_phase = 0;
                    end else begin
                        e.pp = (m_phase == 4);
                        m_phase = (m_phase + 1) % 5;
                    end
                end
            end
            if (c) begin m_cnt = 0; m_cnt2 = 0; end
        end
        e.lk = m_lk; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        chk("locked", locked, g.lk);
        chk("period_pulse", period_pulse, g.pp);
        chk("err_pulse", err_pulse, g.ep);
        chk("err_count", err_count, g.cnt);
        chk("err_count_w2", err_count2, g.cnt2);
        chk("locked_w2", locked2, g.lk);
    endtask

    task automatic send(input logic [4:0] p, input bit gap = 0);
        for (int i = 4; i >= 0; i--) begin
            step(p[i]);
            if (gap) step(1'b1, 1'b0);
        end
    endtask

    initial begin
        // Reset with a valid bit present: it must be discarded.
        step(1, 1, 0, 1);
        chk("reset_locked", locked, 0);
        chk("reset_err", err_count, 0);

        // Clean aligned stream: lock after 10th bit, then periodic pulses.
        send(PAT);
        chk("not_locked_5", locked, 0);
        for (int i = 4; i >= 1; i--) step(PAT[i]);
        chk("not_locked_9", locked, 0);
        step(PAT[0]);
        chk("lock_10", locked, 1);
        chk("lock_10_err", err_count, 0);
        for (int i = 4; i >= 1; i--) step(PAT[i]);
        step(PAT[0]);
        chk("period_pulse_5th", period_pulse, 1);
        send(PAT);

        // Single flipped bit: one error, lock held, schedule kept.
        send(5'b01101);
        chk("single_err_cnt", err_count, 1);
        chk("single_err_lock", locked, 1);
        chk("single_err_pp", period_pulse, 1);

        // Clear, then three consecutive flips at phases 2..4 drop lock.
        step(0, 1, 1);
        for (int i = 3; i >= 0; i--) step(PAT[i]);
        chk("clr_err", err_count, 0);
        send(5'b00010);
        chk("loss_locked", locked, 0);
        chk("loss_err_pulse", err_pulse, 1);
        chk("loss_pp", period_pulse, 0);
        chk("loss_cnt", err_count, 3);
        send(PAT); send(PAT);
        chk("relock", locked, 1);
        chk("relock_cnt", err_count, 3);

        // Misaligned prefix: HUNT matches on bit 8, lock after bit 13.
        step(1, 1, 0, 1);
        chk("reset_while_locked", locked, 0);
        step(1); step(0); step(1);
        send(PAT);
        for (int i = 4; i >= 1; i--) step(PAT[i]);
        chk("prefix_12", locked, 0);
        step(PAT[0]);
        chk("prefix_13", locked, 1);

        // in_valid toggling: lock counted in valid bits, no pulses in gaps.
        step(0, 1, 0, 1);
        send(PAT, 1);
        send(PAT, 1);
        chk("gap_lock", locked, 1);
        send(PAT, 1);

        // Five isolated errors: 16-bit counts 5, 2-bit saturates at 3.
        for (int k = 0; k < 5; k++) send(5'b10101);
        chk("iso_cnt", err_count, 5);
        chk("sat_w2", err_count2, 3);
        chk("iso_locked", locked, 1);

        // clr_err coincident with a mismatch.
        step(1, 1, 1);
        chk("clr_mis_pulse", err_pulse, 1);
        chk("clr_mis_cnt", err_count, 0);
        for (int i = 3; i >= 0; i--) step(PAT[i]);

        // Reset mid-acquisition.
        step(0, 1, 0, 1);
        step(0); step(0); step(1);
        step(0, 1, 0, 1);
        chk("reset_mid_acq", locked, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
